// File: rtl/demux_1ton_reg.sv
// Registered 1-to-N demultiplexer: routes one input word to one of N_OUT lanes, each lane
// holding a single word under valid/ready flow control.
module demux_1ton_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_OUT = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic                   err_sel,
    output logic [7:0]             drop_count
);

    logic [N_OUT-1:0][WIDTH-1:0] data_q;
    logic [N_OUT-1:0]            valid_q;
    logic [N_OUT-1:0]            valid_d;
    logic [N_OUT-1:0]            load;
    logic                        in_range;
    logic                        accept;
    logic                        drop;
    logic                        err_q;
    logic [7:0]                  drop_q;
    logic [31:0]                 sel_ext;

    assign sel_ext = 32'(in_sel);

    // Lane decode by comparison so an out-of-range select never indexes past N_OUT.
    always_comb begin
        in_range = 1'b0;
        in_ready = 1'b1;
        load     = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (sel_ext == k) begin
                in_range = 1'b1;
                in_ready = !valid_q[k] || out_ready[k];
            end
        end
        accept = in_valid && in_ready;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            load[k] = accept && (sel_ext == k);
        end
        drop    = accept && !in_range;
        valid_d = load | (valid_q & ~out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            valid_q <= valid_d;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
            if (drop) begin
                err_q <= 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_q <= drop_q + 8'd1;
                end
            end
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign err_sel    = err_q;
    assign drop_count = drop_q;

endmodule
